logic_unit_pipe: RTL and testbench

//   Parametrised, registered successor to the team's combinational gate blocks.

---
 rtl/logic_unit_pipe_pkg.sv | 18 +
 rtl/logic_op_core.sv | 29 ++
 rtl/logic_unit_pipe.sv | 83 ++++++++
 tb/tb_logic_unit_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// Shared op-code definitions for the logic unit pipeline and anything that drives it.
// Build option: LOGIC_UNIT_PARITY_EN adds a registered parity output to logic_unit_pipe.
package logic_unit_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational bitwise operator: y = f(op, a, b). b is ignored for NOT and PASS.
module logic_op_core
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves y unassigned (no latch).
        y = '0;
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// One-stage valid/ready logic unit with a running XOR accumulator and delivery counter.
// Build option: LOGIC_UNIT_PARITY_EN adds output parity = ^y, registered alongside y.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic [WIDTH-1:0]   acc,
    output logic [COUNT_W-1:0] count
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic               parity
`endif
);

    logic [WIDTH-1:0] f_result;
    logic             accept;
    logic             deliver;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (f_result)
    );

    // The stage refills in the same cycle it drains, so it never inserts a bubble.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop updates from pre-edge values.
            if (accept) begin
                out_valid <= 1'b1;
                y         <= f_result;
            end else if (deliver) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A clear colliding with a delivery restarts the fold from the delivered value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (acc_clr) begin
            acc   <= deliver ? y : '0;
            count <= deliver ? COUNT_W'(1) : '0;
        end else if (deliver) begin
            acc   <= acc ^ y;
            count <= count + COUNT_W'(1);
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= ^f_result;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed scenarios plus random traffic,
// with a second instance at COUNT_W=2 sharing the stimulus to exercise counter wrap.
module tb_logic_unit_pipe;
    import logic_unit_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc_clr;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] y;
    logic [7:0] acc;
    logic [7:0] count;

    logic       w_in_ready;
    logic       w_out_valid;
    logic [7:0] w_y;
    logic [7:0] w_acc;
    logic [1:0] w_count;
`ifdef LOGIC_UNIT_PARITY_EN
    logic       parity;
    logic       w_parity;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .acc       (acc),
        .count     (count)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(2)) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .y         (w_y),
        .acc       (w_acc),
        .count     (w_count)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .parity    (w_parity)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        logic [3:0] tt [8];
        logic [3:0] t;
        logic [7:0] r;
        tt = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
        t = tt[o];
        for (int i = 0; i < 8; i++) r[i] = t[{x[i], z[i]}];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic r, input logic c);
        @(negedge clk);
        in_valid  = v;
        op        = o;
        a         = aa;
        b         = bb;
        out_ready = r;
        acc_clr   = c;
    endtask

    // Scoreboard monitor: model state is the queue of results in flight plus acc and a delivery count.
    logic [7:0] exp_q [$];
    logic [7:0] m_acc = '0;
    int         m_cnt = 0;
    bit         stall_prev = 1'b0;
    logic [7:0] held_y;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                bit         m_full;
                bit         m_del;
                logic [7:0] e;
                m_full = exp_q.size() != 0;
                m_del  = m_full && out_ready;
                check("out_valid", out_valid, m_full);
                check("in_ready", in_ready, !m_full || out_ready);
                check("wrap_out_valid", w_out_valid, m_full);
                if (stall_prev) check("stall_hold_y", y, held_y);
                e = '0;
                if (m_del) begin
                    e = exp_q.pop_front();
                    check("y", y, e);
                    check("wrap_y", w_y, e);
`ifdef LOGIC_UNIT_PARITY_EN
                    check("parity", parity, ^e);
`endif
                end
                if (acc_clr) begin
                    m_acc = '0;
                    m_cnt = 0;
                end
                if (m_del) begin
                    m_acc ^= e;
                    m_cnt++;
                end
                if (in_valid && (!m_full || out_ready)) exp_q.push_back(ref_op(op, a, b));
                stall_prev = m_full && !out_ready;
                held_y     = y;
                @(posedge clk);
                #1;
                check("acc", acc, m_acc);
                check("count", count, 32'(m_cnt % 256));
                check("wrap_count", w_count, 32'(m_cnt % 4));
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1;
        in_valid = 1'b0; op = '0; a = '0; b = '0; acc_clr = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 8'h00);
        check("rst_acc", acc, 8'h00);
        check("rst_count", count, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Op sweep: a=CC, b=AA through all eight ops back to back.
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 8'hCC, 8'hAA, 1'b1, 1'b0);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b0);

        // Backpressure: OR result held for three cycles while the next operand waits.
        drive(1'b1, OP_OR, 8'h0F, 8'hF0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, OP_XOR, 8'h11, 8'h22, 1'b0, 1'b0);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b0);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b0);

        // Accumulate 01, 02, 03 from a cleared state.
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b1);
        drive(1'b1, OP_PASS, 8'h01, 8'h00, 1'b1, 1'b0);
        drive(1'b1, OP_PASS, 8'h02, 8'h00, 1'b1, 1'b0);
        drive(1'b1, OP_PASS, 8'h03, 8'h00, 1'b1, 1'b0);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b0);

        // Clear colliding with delivery of 0F after acc has reached 55.
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b1);
        drive(1'b1, OP_PASS, 8'h55, 8'h00, 1'b1, 1'b0);
        drive(1'b1, OP_PASS, 8'h0F, 8'h00, 1'b1, 1'b0);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b1);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b0);

        // Parity case: 07 has odd weight.
        drive(1'b1, OP_PASS, 8'h07, 8'h00, 1'b1, 1'b0);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b0);
            waited++;
        end
        check("drain_timeout", waited < 50, 1'b1);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b0);
        mon_en = 1'b0;

        // Reset mid-stream: stage full with A5 stalled, acc=3C.
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b1, 1'b1);
        drive(1'b1, OP_PASS, 8'h3C, 8'h00, 1'b1, 1'b0);
        drive(1'b1, OP_PASS, 8'hA5, 8'h00, 1'b1, 1'b0);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        check("pre_rst_out_valid", out_valid, 1'b1);
        check("pre_rst_y", y, 8'hA5);
        check("pre_rst_acc", acc, 8'h3C);
        check("pre_rst_count", count, 8'h01);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_y", y, 8'h00);
        check("mid_rst_acc", acc, 8'h00);
        check("mid_rst_count", count, 8'h00);
        check("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
